// File: rtl/dcache_ctrl_if.sv
// Line-granular handshake between the data cache controller and off-chip data memory.
// The controller drives enable/write/address/write-data; memory answers with read data and a one-cycle ack.
interface dcache_ctrl_if;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport master (
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport slave (
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// A miss stalls the pipeline, optionally writes back a dirty victim, refills the line, then lets the held access hit.
module dcache_ctrl #(
   parameter int LINES = 32,
   parameter int TAG_W = 22
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [31:0]   addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o,
   output logic          stall_o,
   dcache_ctrl_if.master mem
);
   localparam int IDX_W = $clog2(LINES);

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_UPDATE} state_t;

   state_t             r_state;
   logic [LINES-1:0]   r_valid;
   logic [LINES-1:0]   r_dirty;
   logic [TAG_W-1:0]   r_tag_arr  [LINES];
   logic [255:0]       r_data_arr [LINES];
   logic               r_mem_enable;
   logic               r_mem_write;
   logic [31:0]        r_mem_addr;
   logic [255:0]       r_mem_data;
   logic [31:0]        r_alloc_addr;

   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_idx;
   logic [2:0]         w_word;
   logic               w_hit;
   logic               w_idle;
   logic               w_load_hit;
   logic               w_store_hit;
   logic               w_refill;
   logic [IDX_W-1:0]   w_fill_idx;
   logic [TAG_W-1:0]   w_fill_tag;
   logic               w_unused;

   assign w_tag    = addr_i[31 -: TAG_W];
   assign w_idx    = addr_i[5 +: IDX_W];
   assign w_word   = addr_i[4:2];
   assign w_unused = &{1'b0, addr_i[1:0]};

   assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
   assign w_idle      = (r_state == S_IDLE);
   assign w_load_hit  = w_idle && req_i && !we_i && w_hit;
   assign w_store_hit = w_idle && req_i && we_i && w_hit;

   // The refill target comes from the registered request address, so it survives req_i dropping mid-miss.
   assign w_refill   = (r_state == S_ALLOCATE) && mem.mem_ack_i;
   assign w_fill_idx = r_mem_addr[5 +: IDX_W];
   assign w_fill_tag = r_mem_addr[31 -: TAG_W];

   assign rdata_o = w_load_hit ? r_data_arr[w_idx][{w_word, 5'b0} +: 32] : 32'h0;
   // Gated by reset so a held request cannot raise stall while the valid bits are being cleared.
   assign stall_o = rst_i && (!w_idle || (req_i && !w_hit));

   assign mem.mem_enable_o = r_mem_enable;
   assign mem.mem_write_o  = r_mem_write;
   assign mem.mem_addr_o   = r_mem_addr;
   assign mem.mem_data_o   = r_mem_data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_alloc_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_i && !w_hit) begin
                  r_alloc_addr <= {w_tag, w_idx, 5'b0};
                  r_mem_enable <= 1'b1;
                  if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state     <= S_WRITEBACK;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= {r_tag_arr[w_idx], w_idx, 5'b0};
                     r_mem_data  <= r_data_arr[w_idx];
                  end else begin
                     r_state     <= S_ALLOCATE;
                     r_mem_write <= 1'b0;
                     r_mem_addr  <= {w_tag, w_idx, 5'b0};
                  end
               end else if (w_store_hit) begin
                  r_dirty[w_idx] <= 1'b1;
               end
            end
            S_WRITEBACK: begin
               if (mem.mem_ack_i) begin
                  r_state     <= S_ALLOCATE;
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= r_alloc_addr;
                  r_mem_data  <= '0;
               end
            end
            S_ALLOCATE: begin
               if (mem.mem_ack_i) begin
                  r_state             <= S_UPDATE;
                  r_mem_enable        <= 1'b0;
                  r_mem_addr          <= '0;
                  r_valid[w_fill_idx] <= 1'b1;
                  r_dirty[w_fill_idx] <= 1'b0;
               end
            end
            S_UPDATE: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: tag and data arrays are not reset; cleared valid bits make their contents unreachable,
   // and leaving them reset-free lets them map onto RAM.
   always_ff @(posedge clk_i) begin
      if (w_refill) begin
         r_data_arr[w_fill_idx] <= mem.mem_data_i;
         r_tag_arr[w_fill_idx]  <= w_fill_tag;
      end else if (w_store_hit) begin
         r_data_arr[w_idx][{w_word, 5'b0} +: 32] <= wdata_i;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold/dirty/clean misses, store hits, reset mid-writeback and a slow refill.
// The bench plays the memory side and checks every expectation against hand-computed values.
module tb_dcache_ctrl;
   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic [255:0] wb_line;
   int n_checks = 0;
   int n_fail   = 0;

   dcache_ctrl_if mem_if ();

   dcache_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .stall_o (stall),
      .mem     (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      l = '0;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
      return l;
   endfunction

   // Waits (bounded) for a memory request, checks it, holds it for lat cycles, then acks once.
   task automatic serve(input string tag, input logic exp_write, input logic [31:0] exp_addr,
                        input int lat, input logic [255:0] line, output logic [255:0] seen_data);
      int          waited;
      logic        ok;
      logic [31:0] a0;
      waited = 0;
      while (mem_if.mem_enable_o !== 1'b1 && waited < 100) begin
         @(negedge clk); #1;
         waited++;
      end
      check({tag, "_en"},   mem_if.mem_enable_o, 1'b1);
      check({tag, "_wr"},   mem_if.mem_write_o, exp_write);
      check({tag, "_addr"}, mem_if.mem_addr_o, exp_addr);
      seen_data = mem_if.mem_data_o;
      a0 = mem_if.mem_addr_o;
      ok = 1'b1;
      for (int k = 1; k < lat; k++) begin
         @(negedge clk); #1;
         if (mem_if.mem_enable_o !== 1'b1 || mem_if.mem_write_o !== exp_write ||
             mem_if.mem_addr_o !== a0 || stall !== 1'b1 || mem_if.mem_data_o !== seen_data)
            ok = 1'b0;
      end
      check({tag, "_stable"}, ok, 1'b1);
      mem_if.mem_ack_i  = 1'b1;
      mem_if.mem_data_i = line;
      @(negedge clk);
      mem_if.mem_ack_i  = 1'b0;
      mem_if.mem_data_i = '0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      mem_if.mem_ack_i = 1'b0; mem_if.mem_data_i = '0;
      #2;
      check("rst_en",    mem_if.mem_enable_o, 1'b0);
      check("rst_wr",    mem_if.mem_write_o, 1'b0);
      check("rst_addr",  mem_if.mem_addr_o, 32'h0);
      check("rst_data",  mem_if.mem_data_o, 256'h0);
      check("rst_stall", stall, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Cold load miss, ack on the third ALLOCATE cycle
      @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h40; #1;
      check("t1_miss_stall", stall, 1'b1);
      check("t1_idle_en", mem_if.mem_enable_o, 1'b0);
      serve("t1_alloc", 1'b0, 32'h40, 3, mk_line(32'h1111_1111), wb_line);
      check("t1_upd_stall", stall, 1'b1);
      check("t1_upd_en", mem_if.mem_enable_o, 1'b0);
      @(negedge clk); #1;
      check("t1_done_stall", stall, 1'b0);
      check("t1_rdata", rdata, 32'h1111_1111);

      // Store hit then load hit
      @(negedge clk); we = 1'b1; addr = 32'h44; wdata = 32'hDEAD_BEEF; #1;
      check("t2_st_stall", stall, 1'b0);
      check("t2_st_rdata", rdata, 32'h0);
      @(negedge clk); we = 1'b0; #1;
      check("t2_ld_stall", stall, 1'b0);
      check("t2_ld_rdata", rdata, 32'hDEAD_BEEF);
      check("t2_dirty", dut.r_dirty[2], 1'b1);
      @(negedge clk); addr = 32'h48; #1;
      check("t2_w2_rdata", rdata, 32'h1111_1113);

      // Dirty eviction: load 0x440 evicts line 0x40
      @(negedge clk); addr = 32'h440; #1;
      check("t3_miss_stall", stall, 1'b1);
      serve("t3_wb", 1'b1, 32'h40, 2, 256'h0, wb_line);
      check("t3_wb_word1", wb_line[63:32], 32'hDEAD_BEEF);
      check("t3_wb_word0", wb_line[31:0], 32'h1111_1111);
      serve("t3_alloc", 1'b0, 32'h440, 1, mk_line(32'h3333_0000), wb_line);
      check("t3_upd_stall", stall, 1'b1);
      @(negedge clk); #1;
      check("t3_done_stall", stall, 1'b0);
      check("t3_rdata", rdata, 32'h3333_0000);

      // Clean conflict misses go straight to ALLOCATE
      @(negedge clk); addr = 32'h40; #1;
      check("t4a_stall", stall, 1'b1);
      serve("t4a_alloc", 1'b0, 32'h40, 1, mk_line(32'h4444_0000), wb_line);
      @(negedge clk); #1;
      check("t4a_rdata", rdata, 32'h4444_0000);
      @(negedge clk); addr = 32'h840; #1;
      check("t4b_stall", stall, 1'b1);
      serve("t4b_alloc", 1'b0, 32'h840, 2, mk_line(32'h5555_0000), wb_line);
      @(negedge clk); #1;
      check("t4b_rdata", rdata, 32'h5555_0000);

      // Reset in the middle of a WRITEBACK
      @(negedge clk); we = 1'b1; addr = 32'h840; wdata = 32'hCAFE_F00D; #1;
      check("t5_st_stall", stall, 1'b0);
      @(negedge clk); we = 1'b0; addr = 32'h40; #1;
      check("t5_miss_stall", stall, 1'b1);
      @(negedge clk); #1;
      check("t5_wb_en", mem_if.mem_enable_o, 1'b1);
      check("t5_wb_wr", mem_if.mem_write_o, 1'b1);
      check("t5_wb_addr", mem_if.mem_addr_o, 32'h840);
      #2; rst = 1'b0; #1;
      check("t5_rst_en", mem_if.mem_enable_o, 1'b0);
      check("t5_rst_stall", stall, 1'b0);
      req = 1'b0;
      @(negedge clk); rst = 1'b1;
      mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = mk_line(32'hBAD0_0000);
      @(negedge clk);
      mem_if.mem_ack_i = 1'b0; mem_if.mem_data_i = '0; #1;
      check("t5_stray_en", mem_if.mem_enable_o, 1'b0);
      check("t5_stray_stall", stall, 1'b0);
      req = 1'b1; we = 1'b0; addr = 32'h40; #1;
      check("t5_reload_stall", stall, 1'b1);
      serve("t5_reload", 1'b0, 32'h40, 1, mk_line(32'h6666_0000), wb_line);
      @(negedge clk); #1;
      check("t5_rdata", rdata, 32'h6666_0000);

      // Slow refill: 20 ALLOCATE cycles
      @(negedge clk); addr = 32'h60; #1;
      check("t6_miss_stall", stall, 1'b1);
      serve("t6_alloc", 1'b0, 32'h60, 20, mk_line(32'h7777_0000), wb_line);
      check("t6_upd_stall", stall, 1'b1);
      @(negedge clk); #1;
      check("t6_rdata", rdata, 32'h7777_0000);
      check("t6_done_en", mem_if.mem_enable_o, 1'b0);
      @(negedge clk); req = 1'b0; #1;
      check("t6_idle_rdata", rdata, 32'h0);
      check("t6_idle_en", mem_if.mem_enable_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
